// File: rtl/bsg_cache_dma_responder_pkg.sv
// Shared types for the cache DMA responder: the DMA packet layout and the
// responder FSM state encoding.

`ifndef BSG_CACHE_DMA_PKT_DECLARED
`define BSG_CACHE_DMA_PKT_DECLARED
`define DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_mp) \
  typedef struct packed { \
    logic                     write_not_read; \
    logic [addr_width_mp-1:0] addr; \
  } bsg_cache_dma_pkt_s
`endif

package bsg_cache_pkg;

  typedef enum logic [1:0] {
    e_idle    = 2'd0,
    e_rd_wait = 2'd1,
    e_rd_send = 2'd2,
    e_wr_recv = 2'd3
  } bsg_cache_dma_responder_state_e;

  // Counter width for a down-counter that must hold max_val; never narrower than 1.
  function automatic int unsigned counter_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bsg_cache_dma_responder_mem.sv
// Word-addressed backing store for the DMA responder: combinational read,
// synchronous write, whole array cleared by asynchronous reset.

module bsg_cache_dma_responder_mem #(
  parameter int width_p = 32,
  parameter int els_p   = 4096
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [$clog2(els_p)-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o,
  input  logic                     w_v_i,
  input  logic [$clog2(els_p)-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i
);

  logic [width_p-1:0] mem_q [els_p];

  // NOTE: this array is a simulation memory model, so every word is cleared on
  // reset; a real SRAM macro would not be reset and would need no loop here.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bsg_cache_dma_responder.sv
// Memory model answering the DMA side of bsg_cache: returns a block of fill
// data for read packets and absorbs a block of evict data for write packets.

module bsg_cache_dma_responder
  import bsg_cache_pkg::*;
#(
  parameter int data_width_p          = 32,
  parameter int addr_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int els_p                 = 4096,
  parameter int read_delay_p          = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic [addr_width_p:0]   dma_pkt_i,
  input  logic                    dma_pkt_v_i,
  output logic                    dma_pkt_yumi_o,

  output logic [data_width_p-1:0] dma_data_o,
  output logic                    dma_data_v_o,
  input  logic                    dma_data_ready_i,

  input  logic [data_width_p-1:0] dma_data_i,
  input  logic                    dma_data_v_i,
  output logic                    dma_data_yumi_o
);

  localparam int lg_els_lp      = $clog2(els_p);
  localparam int lg_block_lp    = $clog2(block_size_in_words_p);
  localparam int lg_bytes_lp    = $clog2(data_width_p / 8);
  localparam int lg_blocks_lp   = lg_els_lp - lg_block_lp;
  localparam int delay_width_lp = counter_width(read_delay_p);

  `DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_p);

  bsg_cache_dma_pkt_s pkt;
  assign pkt = dma_pkt_i;

  // Only the block-number bits of the address matter: byte offset and word
  // offset are aligned away, and bits above the memory depth alias.
  logic [lg_blocks_lp-1:0] pkt_block;
  logic                    unused_addr_bits;
  assign pkt_block        = pkt.addr[lg_bytes_lp+lg_els_lp-1 : lg_bytes_lp+lg_block_lp];
  assign unused_addr_bits = ^pkt.addr;

  bsg_cache_dma_responder_state_e state_q, state_d;
  logic [lg_block_lp-1:0]         cnt_q, cnt_d;
  logic [delay_width_lp-1:0]      delay_q, delay_d;
  logic [lg_blocks_lp-1:0]        block_q, block_d;

  logic                           pkt_yumi;
  logic                           data_v;
  logic                           data_yumi;
  logic [lg_els_lp-1:0]           mem_addr;
  logic [data_width_p-1:0]        mem_rdata;

  // The block base is aligned, so base + cnt is a plain concatenation.
  assign mem_addr = {block_q, cnt_q};

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    delay_d   = delay_q;
    block_d   = block_q;
    pkt_yumi  = 1'b0;
    data_v    = 1'b0;
    data_yumi = 1'b0;

    case (state_q)
      e_idle: begin
        pkt_yumi = dma_pkt_v_i;
        if (dma_pkt_v_i) begin
          block_d = pkt_block;
          cnt_d   = '0;
          if (pkt.write_not_read) begin
            state_d = e_wr_recv;
          end else if (read_delay_p == 0) begin
            state_d = e_rd_send;
          end else begin
            state_d = e_rd_wait;
            delay_d = delay_width_lp'(read_delay_p);
          end
        end
      end

      e_rd_wait: begin
        delay_d = delay_q - delay_width_lp'(1);
        if (delay_q == delay_width_lp'(1)) begin
          state_d = e_rd_send;
        end
      end

      e_rd_send: begin
        data_v = 1'b1;
        if (dma_data_ready_i) begin
          cnt_d = cnt_q + lg_block_lp'(1);
          if (cnt_q == {lg_block_lp{1'b1}}) begin
            state_d = e_idle;
          end
        end
      end

      e_wr_recv: begin
        data_yumi = dma_data_v_i;
        if (dma_data_v_i) begin
          cnt_d = cnt_q + lg_block_lp'(1);
          if (cnt_q == {lg_block_lp{1'b1}}) begin
            state_d = e_idle;
          end
        end
      end

      default: state_d = e_idle;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the statements execute.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      delay_q <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      block_q <= block_d;
    end
  end

  bsg_cache_dma_responder_mem #(
    .width_p(data_width_p),
    .els_p  (els_p)
  ) mem (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .r_addr_i(mem_addr),
    .r_data_o(mem_rdata),
    .w_v_i   (data_yumi),
    .w_addr_i(mem_addr),
    .w_data_i(dma_data_i)
  );

  // The FSM is forced to IDLE asynchronously, so only the packet handshake
  // needs an explicit reset gate to keep every output low during reset.
  assign dma_pkt_yumi_o  = pkt_yumi & ~reset_i;
  assign dma_data_yumi_o = data_yumi;
  assign dma_data_v_o    = data_v;
  assign dma_data_o      = data_v ? mem_rdata : '0;

endmodule
